// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection; optional perf counters (ID_EX_PERF_CNT_EN).
// Latency: ID inputs appear on EX outputs one cycle later; id_stall is combinational.
// Backpressure: !ex_ready holds the EX register and stalls IF/ID; flush overrides both.
module id_ex_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [11:0]           id_ctrl,
    input  logic [3:0]            id_i_op,
    input  logic [DATA_W-1:0]     id_rs_data,
    input  logic [DATA_W-1:0]     id_rt_data,
    input  logic [15:0]           id_imm,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [DATA_W-1:0]     id_pc4,
    input  logic                  flush,
    input  logic                  ex_ready,
    output logic                  id_stall,
    output logic                  ex_valid,
    output logic [11:0]           ex_ctrl,
    output logic [3:0]            ex_i_op,
    output logic [DATA_W-1:0]     ex_rs_data,
    output logic [DATA_W-1:0]     ex_rt_data,
    output logic [DATA_W-1:0]     ex_imm,
    output logic [REG_ADDR_W-1:0] ex_dest,
    output logic [DATA_W-1:0]     ex_pc4
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [15:0]           stall_cnt,
    output logic [15:0]           flush_cnt
`endif
);

    // Control bus bit positions
    localparam int CTRL_REG_DEST   = 0;
    localparam int CTRL_BEQ        = 2;
    localparam int CTRL_BNE        = 3;
    localparam int CTRL_MEM_WRITE  = 4;
    localparam int CTRL_MEM_READ   = 5;
    localparam int CTRL_LUI_CALLED = 11;

    // EX stage registers
    logic                  ex_valid_q,   ex_valid_d;
    logic [11:0]           ex_ctrl_q,    ex_ctrl_d;
    logic [3:0]            ex_i_op_q,    ex_i_op_d;
    logic [DATA_W-1:0]     ex_rs_data_q, ex_rs_data_d;
    logic [DATA_W-1:0]     ex_rt_data_q, ex_rt_data_d;
    logic [DATA_W-1:0]     ex_imm_q,     ex_imm_d;
    logic [REG_ADDR_W-1:0] ex_dest_q,    ex_dest_d;
    logic [DATA_W-1:0]     ex_pc4_q,     ex_pc4_d;

    // Decode helpers
    logic                  uses_rt;
    logic                  dest_match;
    logic                  hazard;
    logic [REG_ADDR_W-1:0] id_dest;
    logic [DATA_W-1:0]     id_imm_ext;

    // Hazard detection: a load in EX whose destination is read by the ID instruction.
    // rt is a source for R-type (REG_DEST), branches and stores; otherwise it is the I-type target.
    always_comb begin
        uses_rt    = id_ctrl[CTRL_REG_DEST] | id_ctrl[CTRL_BEQ] |
                     id_ctrl[CTRL_BNE] | id_ctrl[CTRL_MEM_WRITE];
        dest_match = (ex_dest_q == id_rs) | (uses_rt & (ex_dest_q == id_rt));
        hazard     = id_valid & ex_valid_q & ex_ctrl_q[CTRL_MEM_READ] &
                     (ex_dest_q != '0) & dest_match;
        // A flushed ID instruction is wrong-path, so never hold it.
        id_stall   = ~flush & (hazard | ~ex_ready);
    end

    // Destination select and immediate extension for the incoming instruction.
    always_comb begin
        id_dest = id_ctrl[CTRL_REG_DEST] ? id_rd : id_rt;
        if (id_ctrl[CTRL_LUI_CALLED]) begin
            id_imm_ext = DATA_W'({id_imm, 16'b0});
        end else begin
            id_imm_ext = {{(DATA_W-16){id_imm[15]}}, id_imm};
        end
    end

    // Next-state for the EX register: flush, then hold on backpressure, then bubble on hazard, else load.
    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_ctrl_d    = ex_ctrl_q;
        ex_i_op_d    = ex_i_op_q;
        ex_rs_data_d = ex_rs_data_q;
        ex_rt_data_d = ex_rt_data_q;
        ex_imm_d     = ex_imm_q;
        ex_dest_d    = ex_dest_q;
        ex_pc4_d     = ex_pc4_q;
        if (flush || (ex_ready && hazard)) begin
            // Bubble: clear everything so a stale operand never looks meaningful.
            ex_valid_d   = 1'b0;
            ex_ctrl_d    = '0;
            ex_i_op_d    = '0;
            ex_rs_data_d = '0;
            ex_rt_data_d = '0;
            ex_imm_d     = '0;
            ex_dest_d    = '0;
            ex_pc4_d     = '0;
        end else if (ex_ready) begin
            ex_valid_d   = id_valid;
            ex_ctrl_d    = id_valid ? id_ctrl : 12'h000;
            ex_i_op_d    = id_i_op;
            ex_rs_data_d = id_rs_data;
            ex_rt_data_d = id_rt_data;
            ex_imm_d     = id_imm_ext;
            ex_dest_d    = id_dest;
            ex_pc4_d     = id_pc4;
        end
    end

    // EX register state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q   <= 1'b0;
            ex_ctrl_q    <= '0;
            ex_i_op_q    <= '0;
            ex_rs_data_q <= '0;
            ex_rt_data_q <= '0;
            ex_imm_q     <= '0;
            ex_dest_q    <= '0;
            ex_pc4_q     <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_ctrl_q    <= ex_ctrl_d;
            ex_i_op_q    <= ex_i_op_d;
            ex_rs_data_q <= ex_rs_data_d;
            ex_rt_data_q <= ex_rt_data_d;
            ex_imm_q     <= ex_imm_d;
            ex_dest_q    <= ex_dest_d;
            ex_pc4_q     <= ex_pc4_d;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_ctrl    = ex_ctrl_q;
    assign ex_i_op    = ex_i_op_q;
    assign ex_rs_data = ex_rs_data_q;
    assign ex_rt_data = ex_rt_data_q;
    assign ex_imm     = ex_imm_q;
    assign ex_dest    = ex_dest_q;
    assign ex_pc4     = ex_pc4_q;

`ifdef ID_EX_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters: bubbles caused by load-use, and squashes of a live EX instruction.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hazard && ex_ready && !flush && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (flush && ex_valid_q && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [11:0] id_ctrl;
    logic [3:0]  id_i_op;
    logic [31:0] id_rs_data, id_rt_data, id_pc4;
    logic [15:0] id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        flush, ex_ready;
    logic        id_stall, ex_valid;
    logic [11:0] ex_ctrl;
    logic [3:0]  ex_i_op;
    logic [31:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
    logic [4:0]  ex_dest;
`ifdef ID_EX_PERF_CNT_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    id_ex_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ctrl(id_ctrl), .id_i_op(id_i_op),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_pc4(id_pc4),
        .flush(flush), .ex_ready(ex_ready), .id_stall(id_stall), .ex_valid(ex_valid),
        .ex_ctrl(ex_ctrl), .ex_i_op(ex_i_op), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_imm(ex_imm), .ex_dest(ex_dest), .ex_pc4(ex_pc4)
`ifdef ID_EX_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Instruction control words (bit 0 REG_DEST ... bit 11 LUI)
    localparam logic [11:0] C_ADD  = 12'h281; // REG_DEST, ALU_OP_1, WRITE_REG
    localparam logic [11:0] C_LW   = 12'h720; // MEM_READ, MEM_TO_REG, WRITE_REG, ALU_SRC
    localparam logic [11:0] C_ADDI = 12'h6C0; // ALU_OP_0/1, WRITE_REG, ALU_SRC
    localparam logic [11:0] C_LUI  = 12'hE00; // WRITE_REG, ALU_SRC, LUI
    localparam logic [11:0] C_SW   = 12'h410; // MEM_WRITE, ALU_SRC
    localparam logic [11:0] C_BEQ  = 12'h044; // BEQ, ALU_OP_0

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;
    logic [31:0] pc = 32'h0040_0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // What EX should hold, as an instruction record.
    logic        m_valid;
    logic [11:0] m_ctrl;
    logic [3:0]  m_iop;
    logic [31:0] m_rsd, m_rtd, m_imm, m_pc4;
    logic [4:0]  m_dest;
    int          m_stalls, m_flushes;

    initial begin
        m_valid = 0; m_ctrl = 0; m_iop = 0; m_rsd = 0; m_rtd = 0;
        m_imm = 0; m_pc4 = 0; m_dest = 0; m_stalls = 0; m_flushes = 0;
    end

    // Does the ID instruction need a register the load in EX has not produced yet?
    function automatic bit m_load_use();
        bit is_load, reads_rt, needs;
        is_load  = m_valid && m_ctrl[5] && (m_dest != 0);
        reads_rt = id_ctrl[0] || id_ctrl[2] || id_ctrl[3] || id_ctrl[4];
        needs    = (id_rs == m_dest) || (reads_rt && id_rt == m_dest);
        return id_valid && is_load && needs;
    endfunction

    function automatic bit m_stall();
        return !flush && (m_load_use() || !ex_ready);
    endfunction

    always @(posedge clk) begin
        bit lu;
        lu = m_load_use();
        if (rst) begin
            m_valid = 0; m_ctrl = 0; m_iop = 0; m_rsd = 0; m_rtd = 0;
            m_imm = 0; m_pc4 = 0; m_dest = 0; m_stalls = 0; m_flushes = 0;
        end else begin
            if (lu && ex_ready && !flush && m_stalls < 65535) m_stalls++;
            if (flush && m_valid && m_flushes < 65535) m_flushes++;
            if (flush || (ex_ready && lu)) begin
                m_valid = 0; m_ctrl = 0; m_iop = 0; m_rsd = 0; m_rtd = 0;
                m_imm = 0; m_pc4 = 0; m_dest = 0;
            end else if (ex_ready) begin
                m_valid = id_valid;
                m_ctrl  = id_valid ? id_ctrl : 12'h0;
                m_iop   = id_i_op;
                m_rsd   = id_rs_data;
                m_rtd   = id_rt_data;
                m_pc4   = id_pc4;
                m_dest  = id_ctrl[0] ? id_rd : id_rt;
                if (id_ctrl[11]) m_imm = {id_imm, 16'h0000};
                else             m_imm = 32'(signed'(id_imm));
            end
        end
    end

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_ex_valid",   {31'b0, ex_valid}, {31'b0, m_valid});
            chk("m_ex_ctrl",    {20'b0, ex_ctrl},  {20'b0, m_ctrl});
            chk("m_ex_i_op",    {28'b0, ex_i_op},  {28'b0, m_iop});
            chk("m_ex_rs_data", ex_rs_data, m_rsd);
            chk("m_ex_rt_data", ex_rt_data, m_rtd);
            chk("m_ex_imm",     ex_imm, m_imm);
            chk("m_ex_dest",    {27'b0, ex_dest}, {27'b0, m_dest});
            chk("m_ex_pc4",     ex_pc4, m_pc4);
            chk("m_id_stall",   {31'b0, id_stall}, {31'b0, m_stall()});
`ifdef ID_EX_PERF_CNT_EN
            chk("m_stall_cnt",  {16'b0, stall_cnt}, 32'(m_stalls));
            chk("m_flush_cnt",  {16'b0, flush_cnt}, 32'(m_flushes));
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [11:0] c, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm);
        id_valid   = v;
        id_ctrl    = c;
        id_i_op    = 4'($urandom_range(0, 15));
        id_rs      = rs;
        id_rt      = rt;
        id_rd      = rd;
        id_imm     = imm;
        id_rs_data = $urandom;
        id_rt_data = $urandom;
        id_pc4     = pc;
        pc         = pc + 32'd4;
    endtask

    task automatic idle();
        set_id(1'b0, 12'h0, 5'd0, 5'd0, 5'd0, 16'h0);
    endtask

    // Present an instruction and clock until EX accepts it; reports cycles spent stalled.
    task automatic issue(input logic [11:0] c, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [15:0] imm, output int stalls);
        set_id(1'b1, c, rs, rt, rd, imm);
        stalls = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (id_stall) begin
                stalls++;
                tick();
            end else begin
                tick();
                return;
            end
        end
        chk("issue_timeout", 32'(stalls), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int st;
        rst = 1'b1; ex_ready = 1'b1; flush = 1'b0;
        idle();

        // Reset with random ID inputs for two cycles.
        for (int i = 0; i < 2; i++) begin
            set_id(1'($urandom), 12'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom));
            flush = 1'($urandom);
            tick();
            chk_en = 1'b1;
        end
        chk("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
        chk("rst_ex_ctrl",  {20'b0, ex_ctrl},  32'd0);
        chk("rst_ex_imm",   ex_imm, 32'd0);
        chk("rst_id_stall", {31'b0, id_stall}, 32'd0);
        rst = 1'b0; flush = 1'b0;
        idle();
        tick();

        // Plain ADDI pass-through.
        issue(C_ADDI, 5'd4, 5'd9, 5'd0, 16'hFFFC, st);
        chk("addi_ex_dest",  {27'b0, ex_dest}, 32'd9);
        chk("addi_ex_imm",   ex_imm, 32'hFFFF_FFFC);
        chk("addi_ex_valid", {31'b0, ex_valid}, 32'd1);
        chk("addi_ex_ctrl",  {20'b0, ex_ctrl}, 32'h6C0);

        // Load-use: LW $8 then ADD $10 = $8 + $5.
        issue(C_LW, 5'd3, 5'd8, 5'd0, 16'h0010, st);
        set_id(1'b1, C_ADD, 5'd8, 5'd5, 5'd10, 16'h0);
        #1;
        chk("lu_stall_on", {31'b0, id_stall}, 32'd1);
        tick();
        chk("lu_bubble_valid", {31'b0, ex_valid}, 32'd0);
        chk("lu_bubble_ctrl",  {20'b0, ex_ctrl}, 32'd0);
        chk("lu_stall_off",    {31'b0, id_stall}, 32'd0);
        tick();
        chk("lu_add_valid", {31'b0, ex_valid}, 32'd1);
        chk("lu_add_dest",  {27'b0, ex_dest}, 32'd10);

        // Load to $0 never stalls.
        issue(C_LW, 5'd3, 5'd0, 5'd0, 16'h0004, st);
        issue(C_ADD, 5'd0, 5'd0, 5'd11, 16'h0, st);
        chk("lw0_no_stall", 32'(st), 32'd0);

        // ADDI whose rt is the load target: rt is a destination, not a source.
        issue(C_LW, 5'd3, 5'd8, 5'd0, 16'h0008, st);
        issue(C_ADDI, 5'd3, 5'd8, 5'd0, 16'h0001, st);
        chk("addi_rt_no_stall", 32'(st), 32'd0);

        // Backpressure for three cycles holds EX and stalls ID.
        issue(C_ADD, 5'd1, 5'd2, 5'd11, 16'h0, st);
        ex_ready = 1'b0;
        set_id(1'b1, C_ADDI, 5'd1, 5'd12, 5'd0, 16'h0005);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_stall", {31'b0, id_stall}, 32'd1);
            tick();
            chk("bp_hold_dest", {27'b0, ex_dest}, 32'd11);
        end
        ex_ready = 1'b1;
        tick();
        chk("bp_release_dest", {27'b0, ex_dest}, 32'd12);
        chk("bp_release_imm",  ex_imm, 32'd5);

        // Flush during a hazard: no stall, bubble.
        issue(C_LW, 5'd2, 5'd8, 5'd0, 16'h0000, st);
        set_id(1'b1, C_ADD, 5'd8, 5'd1, 5'd13, 16'h0);
        flush = 1'b1;
        #1;
        chk("flush_no_stall", {31'b0, id_stall}, 32'd0);
        tick();
        flush = 1'b0;
        chk("flush_bubble_valid", {31'b0, ex_valid}, 32'd0);
        chk("flush_bubble_ctrl",  {20'b0, ex_ctrl}, 32'd0);

        // LUI immediate.
        issue(C_LUI, 5'd0, 5'd7, 5'd0, 16'h1234, st);
        chk("lui_imm", ex_imm, 32'h1234_0000);

        // Reset asserted while ID is stalled.
        issue(C_LW, 5'd3, 5'd8, 5'd0, 16'h0000, st);
        set_id(1'b1, C_ADD, 5'd8, 5'd8, 5'd14, 16'h0);
        #1;
        chk("rstmid_stall_on", {31'b0, id_stall}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_stall_off", {31'b0, id_stall}, 32'd0);
        chk("rstmid_valid",     {31'b0, ex_valid}, 32'd0);
        idle();
        tick();

        // Back-to-back dependent loads, then a store reading the loaded rt.
        issue(C_LW, 5'd3, 5'd8, 5'd0, 16'h0000, st);
        issue(C_LW, 5'd8, 5'd9, 5'd0, 16'h0000, st);
        chk("b2b_lw_stalls", 32'(st), 32'd1);
        issue(C_ADD, 5'd9, 5'd2, 5'd15, 16'h0, st);
        chk("b2b_add_stalls", 32'(st), 32'd1);
        issue(C_LW, 5'd3, 5'd4, 5'd0, 16'h0000, st);
        issue(C_SW, 5'd1, 5'd4, 5'd0, 16'h0000, st);
        chk("sw_rt_stalls", 32'(st), 32'd1);
`ifdef ID_EX_PERF_CNT_EN
        chk("stall_cnt_3", {16'b0, stall_cnt}, 32'd3);
        flush = 1'b1;
        idle();
        tick();
        flush = 1'b0;
        chk("flush_cnt_1", {16'b0, flush_cnt}, 32'd1);
`endif
        issue(C_BEQ, 5'd4, 5'd4, 5'd0, 16'hFFF0, st);
        chk("beq_imm", ex_imm, 32'hFFFF_FFF0);

        // Random traffic on a few registers, checked by the model every cycle.
        for (int i = 0; i < 300; i++) begin
            logic [11:0] c;
            case ($urandom_range(0, 5))
                0: c = C_ADD;  1: c = C_LW;  2: c = C_ADDI;
                3: c = C_LUI;  4: c = C_SW;  default: c = C_BEQ;
            endcase
            set_id(1'($urandom_range(0, 3) != 0), c, 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom));
            flush    = ($urandom_range(0, 7) == 0);
            ex_ready = ($urandom_range(0, 3) != 0);
            rst      = ($urandom_range(0, 49) == 0);
            tick();
        end
        rst = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register and load-use hazard unit for the five-stage MIPS core. It sits directly downstream of `control_unit_module`. It captures that unit's 12-bit control bus and 4-bit I-type ALU op, together with the decoded operands from the register file and instruction fields, and presents them to the EX stage one cycle later. It detects load-use hazards, inserts bubbles, stalls IF/ID, and honours branch flush and EX backpressure.

## Interface
- `DATA_W`, 32, datapath width
- `REG_ADDR_W`, 5, register index width
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `id_valid`  in  1  ID holds a valid instruction
- `id_ctrl`  in  12  control bus; bit order: 0 REG_DEST, 1 JUMP, 2 BEQ, 3 BNE, 4 MEM_WRITE, 5 MEM_READ, 6 ALU_OP_0, 7 ALU_OP_1, 8 MEM_TO_REG, 9 WRITE_REG, 10 ALU_SRC, 11 LUI_CALLED
- `id_i_op`  in  4  I-type ALU op
- `id_rs_data`, `id_rt_data`  in  DATA_W  register file read data
- `id_imm`  in  16  instruction [15:0]
- `id_rs`, `id_rt`, `id_rd`  in  REG_ADDR_W  register indices
- `id_pc4`  in  DATA_W  PC+4 of the ID instruction
- `flush`  in  1  branch/jump resolved taken in EX; squash
- `ex_ready`  in  1  EX accepts a new instruction this cycle
- `id_stall`  out  1  hold PC and IF/ID (combinational)
- `ex_valid`  out  1  EX register holds a real instruction
- `ex_ctrl`  out  12  registered control bus
- `ex_i_op`  out  4  registered ALU op
- `ex_rs_data`, `ex_rt_data`  out  DATA_W  registered operands
- `ex_imm`  out  DATA_W  extended immediate
- `ex_dest`  out  REG_ADDR_W  write-back register index
- `ex_pc4`  out  DATA_W  registered PC+4

## Operation
- Register update on each rising edge, in priority order:
  1. `rst`: all outputs are 0, including `ex_valid`.
  2. `flush`: bubble (`ex_valid`=0, `ex_ctrl`=0, `ex_i_op`=0). Data fields are don't-care but are cleared to 0.
  3. `!ex_ready`: hold all EX registers.
  4. `hazard`: bubble, as in case 2.
  5. Otherwise: load the ID inputs. `ex_valid` takes `id_valid`. If `id_valid`=0, `ex_ctrl` is loaded as 0.
- `uses_rt` = `id_ctrl[0] | id_ctrl[2] | id_ctrl[3] | id_ctrl[4]`.
- `hazard` = `id_valid & ex_valid & ex_ctrl[5] & (ex_dest != 0) & ((ex_dest == id_rs) | (uses_rt & ex_dest == id_rt))`.
- `id_stall` = `!flush & (hazard | !ex_ready)`. It is 0 during `flush`, because the instruction in ID is wrong-path.
- `ex_dest` is loaded as `id_rd` when `id_ctrl[0]`=1, else `id_rt`.
- `ex_imm` extension:
  - `id_ctrl[11]`=1 (LUI): `{id_imm, 16'b0}`.
  - Otherwise: sign-extend `id_imm` to DATA_W.
- Only MEM_READ triggers a hazard; ALU results are forwarded in EX by a separate unit.

## Timing
- Latency from ID inputs to EX outputs: 1 cycle.
- `id_stall` is combinational from the current EX registers and ID inputs, valid in the same cycle.
- A load-use hazard costs exactly 1 bubble. After the bubble, `ex_ctrl[5]`=0, so `hazard` drops and the held ID instruction loads on the next edge.
- Back-to-back loads into dependent consumers: each consumer is stalled once.
- `flush` together with `hazard` or `!ex_ready`: `flush` wins and the EX register becomes a bubble.
- `rst` asserted mid-stall: next edge clears everything, and `id_stall` drops the same cycle because `ex_valid`=0.

## Configuration
- Macro: `ID_EX_PERF_CNT_EN`.
- When defined, two extra output ports exist:
  - `stall_cnt[15:0]` counts cycles with `hazard & ex_ready & !flush`.
  - `flush_cnt[15:0]` counts cycles with `flush & ex_valid`.
  - Both counters saturate at 16'hFFFF and clear on `rst`.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

## Test plan
- Reset: assert `rst` 2 cycles with random inputs -> all outputs 0, `id_stall`=0.
- Plain pass-through: ADDI with `id_rt`=9, `id_imm`=16'hFFFC, `id_ctrl`=12'h6C0 -> next cycle `ex_dest`=9, `ex_imm`=32'hFFFFFFFC, `ex_valid`=1.
- Load-use: LW to $8, then ADD with rs=$8 -> `id_stall`=1 for exactly 1 cycle, one bubble (`ex_ctrl`=0), ADD appears in EX 2 cycles after LW.
- Hazard suppressed:
  - LW to $0 followed by a consumer of $0 -> no stall.
  - LW to $8 followed by ADDI with rt=8 (`uses_rt`=0) -> no stall.
- Flush and backpressure:
  - `ex_ready`=0 for 3 cycles -> EX regs held and `id_stall`=1.
  - `flush`=1 during a hazard -> bubble, `id_stall`=0.
- LUI and counters: LUI with imm 16'h1234 -> `ex_imm`=32'h12340000. With `ID_EX_PERF_CNT_EN`, 3 load-use hazards -> `stall_cnt`=3.
